// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundles every non-clock/reset signal of the fetch queue: the
//   instruction-memory request/response pair, the redirect input and the
//   two-slot decode presentation with its dequeue count.
//   master : the fetch queue side (drives address, request and decode slots)
//   slave  : the environment side (memory, redirect source and decode)
interface fetch_queue_if;
    logic        io_fetch_en;
    logic [63:0] io_if_mem_instAddr;
    logic        io_if_req;
    logic [31:0] io_mem_id_inst_0;
    logic [31:0] io_mem_id_inst_1;
    logic        io_redirect_valid;
    logic [63:0] io_redirect_pc;
    logic        io_id_valid_0;
    logic        io_id_valid_1;
    logic [31:0] io_id_inst_0;
    logic [31:0] io_id_inst_1;
    logic [63:0] io_id_pc_0;
    logic [63:0] io_id_pc_1;
    logic [1:0]  io_id_deq;

    modport master (
        input  io_fetch_en, io_mem_id_inst_0, io_mem_id_inst_1,
               io_redirect_valid, io_redirect_pc, io_id_deq,
        output io_if_mem_instAddr, io_if_req,
               io_id_valid_0, io_id_valid_1, io_id_inst_0, io_id_inst_1,
               io_id_pc_0, io_id_pc_1
    );

    modport slave (
        output io_fetch_en, io_mem_id_inst_0, io_mem_id_inst_1,
               io_redirect_valid, io_redirect_pc, io_id_deq,
        input  io_if_mem_instAddr, io_if_req,
               io_id_valid_0, io_id_valid_1, io_id_inst_0, io_id_inst_1,
               io_id_pc_0, io_id_pc_1
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch front-end. Presents the fetch PC to a synchronous
//   dual-word instruction memory, captures the two returned words (addr and
//   addr+4) one cycle later into a circular queue, and shows the two oldest
//   queued instructions with their PCs to decode. A redirect flushes the
//   queue and any in-flight response and restarts fetch at the new PC.
//
//   clock : system clock
//   reset : asynchronous, active-low reset
//   bus   : fetch_queue_if.master
//           io_fetch_en              fetch permitted
//           io_if_mem_instAddr/req   fetch address / fetch issued
//           io_mem_id_inst_0/1       memory words for previous cycle's address
//           io_redirect_valid/pc     flush and restart at pc (bits [1:0] dropped)
//           io_id_valid/inst/pc_0/1  decode slots, oldest in slot 0
//           io_id_deq                slots consumed by decode (0..2)
module fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic          clock,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // An issue is allowed while queued plus reserved entries leave room for a pair.
    localparam logic [CNT_W-1:0] ISSUE_LIMIT = CNT_W'(DEPTH - 2);

    // Saturate the decode dequeue request to the number of valid slots.
    function automatic logic [1:0] sat_deq(input logic [1:0]       want,
                                           input logic [CNT_W-1:0] avail);
        logic [1:0] lim;
        lim = (avail >= CNT_W'(2)) ? 2'd2 : avail[1:0];
        return (want > lim) ? lim : want;
    endfunction

    logic [63:0]      pc_p0;
    logic             vld_p1;
    logic [63:0]      pc_p1;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [31:0]      inst_q [DEPTH];
    logic [63:0]      pc_q   [DEPTH];

    logic [CNT_W-1:0] committed;
    logic             issue;
    logic             enq;
    logic [1:0]       deq;
    logic [PTR_W-1:0] head_nx;
    logic [PTR_W-1:0] tail_nx;

    // Stage 0: fetch address and issue decision from registered state only;
    // entries freed by this cycle's dequeue are deliberately not counted.
    assign committed = count + (vld_p1 ? CNT_W'(2) : CNT_W'(0));
    assign issue     = reset & bus.io_fetch_en & ~bus.io_redirect_valid
                     & (committed <= ISSUE_LIMIT);

    assign bus.io_if_mem_instAddr = pc_p0;
    assign bus.io_if_req          = issue;

    // Stage 1: the memory response for last cycle's issue; a redirect kills it.
    assign enq     = vld_p1 & ~bus.io_redirect_valid;
    assign deq     = sat_deq(bus.io_id_deq, count);
    assign head_nx = head + PTR_W'(1);
    assign tail_nx = tail + PTR_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_p0  <= RESET_PC;
            vld_p1 <= 1'b0;
            count  <= '0;
            head   <= '0;
            tail   <= '0;
        end else if (bus.io_redirect_valid) begin
            pc_p0  <= bus.io_redirect_pc & ~64'h3;
            vld_p1 <= 1'b0;
            count  <= '0;
            head   <= tail;
        end else begin
            if (issue) begin
                pc_p0 <= pc_p0 + 64'd8;
            end
            vld_p1 <= issue;
            head   <= head + PTR_W'(deq);
            if (enq) begin
                tail <= tail + PTR_W'(2);
            end
            count <= count + (enq ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(deq);
        end
    end

    // Queue storage: data only, qualified by count/vld_p1 so it needs no reset.
    always_ff @(posedge clock) begin
        if (issue) begin
            pc_p1 <= pc_p0;
        end
        if (enq) begin
            inst_q[tail]    <= bus.io_mem_id_inst_0;
            pc_q[tail]      <= pc_p1;
            inst_q[tail_nx] <= bus.io_mem_id_inst_1;
            pc_q[tail_nx]   <= pc_p1 + 64'd4;
        end
    end

    // Decode slots
    assign bus.io_id_valid_0 = (count != '0);
    assign bus.io_id_valid_1 = (count >= CNT_W'(2));
    assign bus.io_id_inst_0  = inst_q[head];
    assign bus.io_id_pc_0    = pc_q[head];
    assign bus.io_id_inst_1  = inst_q[head_nx];
    assign bus.io_id_pc_1    = pc_q[head_nx];
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    localparam int DEPTH = 8;

    typedef struct {
        logic        fe;
        logic [1:0]  deq;
        logic        req;
        logic [63:0] addr;
        logic        v0;
        logic        v1;
        logic [63:0] pc0;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] key   = 32'h0;
    logic [63:0] last_addr = 64'h0;

    ent_t        mq[$];
    logic [63:0] mpc;
    int          mpend;
    logic [63:0] mpend_pc;

    always #5 clock = ~clock;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Decode must never ask for more slots than are valid.
    always @(negedge clock) begin
        if (reset && (bus.io_id_deq > ({1'b0, bus.io_id_valid_0} + {1'b0, bus.io_id_valid_1})))
            $error("decode over-dequeue: deq=%0d", bus.io_id_deq);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fe, input logic [1:0] deq, input logic rv, input logic [63:0] rpc);
        bus.io_fetch_en       = fe;
        bus.io_id_deq         = deq;
        bus.io_redirect_valid = rv;
        bus.io_redirect_pc    = rpc;
    endtask

    // One clock; the memory model returns words for the address seen before the edge.
    task automatic tick();
        last_addr = bus.io_if_mem_instAddr;
        @(posedge clock);
        #1;
        bus.io_mem_id_inst_0 = last_addr[31:0] ^ key;
        bus.io_mem_id_inst_1 = (last_addr[31:0] + 32'd4) ^ key;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 64'h0);
        bus.io_mem_id_inst_0 = '0;
        bus.io_mem_id_inst_1 = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic check_out(input string tag, input logic req, input logic [63:0] addr,
                             input logic v0, input logic v1, input logic [63:0] pc0);
        logic [63:0] pc1;
        pc1 = pc0 + 64'd4;
        check({tag, " req"},  64'(bus.io_if_req), 64'(req));
        check({tag, " addr"}, bus.io_if_mem_instAddr, addr);
        check({tag, " v0"},   64'(bus.io_id_valid_0), 64'(v0));
        check({tag, " v1"},   64'(bus.io_id_valid_1), 64'(v1));
        if (v0) begin
            check({tag, " pc0"},   bus.io_id_pc_0, pc0);
            check({tag, " inst0"}, 64'(bus.io_id_inst_0), 64'(pc0[31:0]));
        end
        if (v1) begin
            check({tag, " pc1"},   bus.io_id_pc_1, pc1);
            check({tag, " inst1"}, 64'(bus.io_id_inst_1), 64'(pc1[31:0]));
        end
    endtask

    task automatic run_rows(input string tag, input vec_t rows[$]);
        foreach (rows[i]) begin
            drive(rows[i].fe, rows[i].deq, 1'b0, 64'h0);
            #1;
            check_out($sformatf("%s[%0d]", tag, i), rows[i].req, rows[i].addr,
                      rows[i].v0, rows[i].v1, rows[i].pc0);
            tick();
        end
    endtask

    initial begin
        vec_t fill[$];
        vec_t stream[$];

        // Fill with no dequeue: four fetches, then full; one deq=2 frees one pair.
        fill = '{
            '{1'b1, 2'd0, 1'b1, 64'd0,  1'b0, 1'b0, 64'd0},
            '{1'b1, 2'd0, 1'b1, 64'd8,  1'b0, 1'b0, 64'd0},
            '{1'b1, 2'd0, 1'b1, 64'd16, 1'b1, 1'b1, 64'd0},
            '{1'b1, 2'd0, 1'b1, 64'd24, 1'b1, 1'b1, 64'd0},
            '{1'b1, 2'd0, 1'b0, 64'd32, 1'b1, 1'b1, 64'd0},
            '{1'b1, 2'd0, 1'b0, 64'd32, 1'b1, 1'b1, 64'd0},
            '{1'b1, 2'd0, 1'b0, 64'd32, 1'b1, 1'b1, 64'd0},
            '{1'b1, 2'd2, 1'b0, 64'd32, 1'b1, 1'b1, 64'd0},
            '{1'b1, 2'd0, 1'b1, 64'd32, 1'b1, 1'b1, 64'd8},
            '{1'b1, 2'd0, 1'b0, 64'd40, 1'b1, 1'b1, 64'd8},
            '{1'b1, 2'd0, 1'b0, 64'd40, 1'b1, 1'b1, 64'd8}
        };
        // Streaming with deq=2 once slots are valid: no bubbles after fill.
        stream = '{
            '{1'b1, 2'd0, 1'b1, 64'd0,  1'b0, 1'b0, 64'd0},
            '{1'b1, 2'd0, 1'b1, 64'd8,  1'b0, 1'b0, 64'd0},
            '{1'b1, 2'd2, 1'b1, 64'd16, 1'b1, 1'b1, 64'd0},
            '{1'b1, 2'd2, 1'b1, 64'd24, 1'b1, 1'b1, 64'd8},
            '{1'b1, 2'd2, 1'b1, 64'd32, 1'b1, 1'b1, 64'd16},
            '{1'b1, 2'd2, 1'b1, 64'd40, 1'b1, 1'b1, 64'd24}
        };

        // Reset state, with fetch_en high while reset is held.
        reset = 1'b0;
        drive(1'b1, 2'd0, 1'b0, 64'h0);
        bus.io_mem_id_inst_0 = '0;
        bus.io_mem_id_inst_1 = '0;
        #2;
        check_out("reset", 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);

        do_reset();
        run_rows("stream", stream);
        do_reset();
        run_rows("fill", fill);

        // Redirect to 0x1003 with a fetch in flight and a non-empty queue.
        do_reset();
        repeat (3) begin drive(1'b1, 2'd0, 1'b0, 64'h0); tick(); end
        drive(1'b1, 2'd0, 1'b1, 64'h1003);
        #1;
        check("redir req", 64'(bus.io_if_req), 64'd0);
        check("redir pre v0", 64'(bus.io_id_valid_0), 64'd1);
        tick();
        drive(1'b1, 2'd0, 1'b0, 64'h0);
        #1;
        check_out("redir+1", 1'b1, 64'h1000, 1'b0, 1'b0, 64'h0);
        tick();
        #1;
        check_out("redir+2", 1'b1, 64'h1008, 1'b0, 1'b0, 64'h0);
        tick();
        #1;
        check_out("redir+3", 1'b1, 64'h1010, 1'b1, 1'b1, 64'h1000);
        tick();

        // fetch_en drops with one fetch in flight; then re-enable.
        do_reset();
        drive(1'b1, 2'd0, 1'b0, 64'h0);
        #1 check_out("fen c0", 1'b1, 64'h0, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 64'h0);
        #1 check_out("fen c1", 1'b0, 64'h8, 1'b0, 1'b0, 64'h0);
        tick();
        #1 check_out("fen c2", 1'b0, 64'h8, 1'b1, 1'b1, 64'h0);
        tick();
        #1 check_out("fen c3", 1'b0, 64'h8, 1'b1, 1'b1, 64'h0);
        tick();
        drive(1'b1, 2'd0, 1'b0, 64'h0);
        #1 check_out("fen c4", 1'b1, 64'h8, 1'b1, 1'b1, 64'h0);
        tick();
        #1 check_out("fen c5", 1'b1, 64'h10, 1'b1, 1'b1, 64'h0);
        tick();
        #1 check_out("fen c6", 1'b1, 64'h18, 1'b1, 1'b1, 64'h0);
        tick();

        // Asynchronous reset between edges with five entries queued.
        do_reset();
        repeat (3) begin drive(1'b1, 2'd0, 1'b0, 64'h0); tick(); end
        drive(1'b1, 2'd1, 1'b0, 64'h0);
        tick();
        drive(1'b1, 2'd0, 1'b0, 64'h0);
        #1 check_out("cnt5", 1'b0, 64'd32, 1'b1, 1'b1, 64'h4);
        #1 reset = 1'b0;
        #1 check_out("async rst", 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        @(posedge clock);
        #1 reset = 1'b1;
        drive(1'b1, 2'd0, 1'b0, 64'h0);
        #1 check_out("post rst c0", 1'b1, 64'h0, 1'b0, 1'b0, 64'h0);
        tick();
        #1 check_out("post rst c1", 1'b1, 64'h8, 1'b0, 1'b0, 64'h0);
        tick();
        #1 check_out("post rst c2", 1'b1, 64'h10, 1'b1, 1'b1, 64'h0);
        tick();

        // Randomized run against a queue-based reference model.
        do_reset();
        key = 32'h5A3C_0000;
        bus.io_mem_id_inst_0 = key;
        bus.io_mem_id_inst_1 = key;
        mq.delete();
        mpc   = 64'h0;
        mpend = 0;
        mpend_pc = 64'h0;
        for (int n = 0; n < 3000; n++) begin
            logic        fe;
            logic        rv;
            logic [63:0] rpc;
            logic [1:0]  deq;
            logic        e_req;
            int          maxd;
            string       tag;
            fe  = ($urandom_range(0, 4) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)}
                                              : {$urandom, $urandom};
            maxd = (mq.size() >= 2) ? 2 : mq.size();
            deq  = 2'($urandom_range(0, maxd));
            e_req = fe && !rv && ((DEPTH - mq.size() - 2 * mpend) >= 2);
            drive(fe, deq, rv, rpc);
            #1;
            tag = $sformatf("rnd%0d", n);
            check({tag, " req"},  64'(bus.io_if_req), 64'(e_req));
            check({tag, " addr"}, bus.io_if_mem_instAddr, mpc);
            check({tag, " v0"},   64'(bus.io_id_valid_0), 64'(mq.size() >= 1));
            check({tag, " v1"},   64'(bus.io_id_valid_1), 64'(mq.size() >= 2));
            if (mq.size() >= 1) begin
                check({tag, " pc0"},   bus.io_id_pc_0, mq[0].pc);
                check({tag, " inst0"}, 64'(bus.io_id_inst_0), 64'(mq[0].inst));
            end
            if (mq.size() >= 2) begin
                check({tag, " pc1"},   bus.io_id_pc_1, mq[1].pc);
                check({tag, " inst1"}, 64'(bus.io_id_inst_1), 64'(mq[1].inst));
            end
            tick();
            if (rv) begin
                mq.delete();
                mpend = 0;
                mpc   = rpc & ~64'h3;
            end else begin
                repeat (int'(deq)) void'(mq.pop_front());
                if (mpend != 0) begin
                    logic [63:0] p4;
                    p4 = mpend_pc + 64'd4;
                    mq.push_back('{mpend_pc[31:0] ^ key, mpend_pc});
                    mq.push_back('{p4[31:0] ^ key, p4});
                end
                if (e_req) begin
                    mpend_pc = mpc;
                    mpc      = mpc + 64'd8;
                end
                mpend = e_req ? 1 : 0;
            end
            if (mq.size() > DEPTH) begin
                total++;
                bad++;
                $display("FAIL %s model overflow: size %0d limit %0d", tag, mq.size(), DEPTH);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front-end sitting directly upstream of the instruction memory's dual-fetch port.
- Drives a 64-bit fetch address into the memory each cycle. Captures the two 32-bit instructions the memory returns (words at addr and addr+4) into a FIFO.
- Presents up to two in-order instructions per cycle, with their PCs, to decode.
- Handles redirects (branch/jump/flush) by discarding queued and in-flight instructions.

Parameters:
- DEPTH, 8, queue entries (power of two, ≥4); each entry holds {inst[31:0], pc[63:0]}.
- RESET_PC, 64'h0, fetch PC loaded at reset.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- io_fetch_en  in  1  1 = fetching permitted; 0 = stop issuing new fetches (queue still drains)
- io_if_mem_instAddr  out  64  fetch address to instruction memory
- io_if_req  out  1  fetch issued this cycle
- io_mem_id_inst_0  in  32  memory word at the previous cycle's address
- io_mem_id_inst_1  in  32  memory word at the previous cycle's address +4
- io_redirect_valid  in  1  flush and redirect
- io_redirect_pc  in  64  new fetch PC; bits [1:0] ignored (forced 0)
- io_id_valid_0  out  1  slot 0 holds a valid instruction
- io_id_valid_1  out  1  slot 1 holds a valid instruction (only if slot 0 is valid)
- io_id_inst_0, io_id_inst_1  out  32  instructions, oldest in slot 0
- io_id_pc_0, io_id_pc_1  out  64  PCs of the slot instructions
- io_id_deq  in  2  number of slots decode consumes this cycle (0..2)

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, count=0, head=tail=0, inflight=0.
  - All io_id_valid_* = 0; io_if_req = 0; io_if_mem_instAddr = RESET_PC.
- Memory timing: synchronous read. Data for an address presented in cycle t is valid on io_mem_id_inst_0/1 in cycle t+1.
- Issue rule, evaluated on registered state:
  - io_if_req = io_fetch_en & ~io_redirect_valid & (DEPTH - count - 2*inflight ≥ 2).
  - Same-cycle dequeue is not credited (conservative).
- Address and PC update:
  - io_if_mem_instAddr = pc at all times.
  - On io_if_req: pc <= pc+8; inflight <= 1; captured_pc <= pc.
  - Otherwise inflight <= 0.
- Response: in the cycle after an issue (inflight=1, no redirect), enqueue inst_0 with captured_pc and then inst_1 with captured_pc+4. Both enter in one cycle.
- Dequeue:
  - io_id_deq entries leave from the head.
  - io_id_deq > number of valid slots is a decode protocol error. Clamp it to the valid count. The bench asserts this never happens.
  - Enqueue and dequeue in the same cycle: count <= count + 2*enq - deq. head and tail wrap modulo DEPTH.
- Output slots (combinational from head):
  - valid_0 = count≥1; valid_1 = count≥2.
  - Slots show entry[head] and entry[head+1 mod DEPTH].
- Redirect (io_redirect_valid=1, registered at clock edge):
  - count <= 0, head <= tail; inflight <= 0.
  - A response arriving in the same cycle is dropped.
  - pc <= {io_redirect_pc[63:2],2'b00}; no fetch issued that cycle.
  - Next cycle: io_if_mem_instAddr = redirect pc, and fetch resumes if enabled.
  - Redirect takes priority over enqueue, dequeue and issue.
- Full: count never exceeds DEPTH; the issue rule guarantees space.
- Empty: valid outputs are 0; data outputs are don't-care.
- pc arithmetic wraps modulo 2^64.
- io_fetch_en deasserted mid-stream:
  - An already in-flight response is still enqueued.
  - pc holds.
- Reset asserted mid-operation: immediate return to the reset state; queue contents are discarded.

Test Plan:
- Reset release with RESET_PC=0, fetch_en=1, memory returning word=addr, io_id_deq=2 every cycle:
  - Required: addresses 0,8,16… on consecutive cycles.
  - Required: from cycle 2, slots show (0x0/pc0, 0x4/pc4), then (0x8,0xC)…; no bubbles after fill.
- io_id_deq=0 constantly, DEPTH=8:
  - Required: exactly 4 fetches issued (addresses 0,8,16,24); count=8.
  - Required: io_if_req stays 0 afterwards; pc=32.
- Full queue, then a single cycle of io_id_deq=2:
  - Required: one fetch issued the following cycle (addr 32); count returns to 8 with no overflow.
- Redirect to 0x1003 while a fetch is in flight and the queue is non-empty:
  - Required: next cycle valid_0=0 and addr=0x1000.
  - Required: the in-flight data is dropped; the first delivered instruction has pc 0x1000.
- fetch_en toggled 1→0 with one fetch in flight:
  - Required: that pair is enqueued, then no further io_if_req and pc frozen.
  - Required: re-enable resumes at the frozen pc.
- Asynchronous reset asserted between clock edges while count=5:
  - Required: outputs clear immediately without waiting for a clock edge.
  - Required: after release, fetch restarts at RESET_PC.
